// File: rtl/ov7670_capture_pkg.sv
// Shared types and defaults for the OV7670 parallel-bus capture path.
// Holds the FSM encoding, the RGB565 field layout and the default frame geometry.
package ov7670_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int XW_DEF       = 10;
  localparam int YW_DEF       = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_SYNC      = 2'd2,
    ST_ACTIVE    = 2'd3
  } state_t;

  // R[15:11] G[10:5] B[4:0]. The camera sends the byte holding R first.
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes into one RGB565 word and strobes it for one cycle.
// clear drops any half-assembled pixel and any strobe that is about to be issued.
module ov7670_byte_pair
  import ov7670_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] pix,
  output logic        pix_strobe,
  output logic        phase
);

  logic    [7:0] r_hi;
  rgb565_t       r_pix;
  logic          r_strobe;
  logic          r_phase;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_pix    <= '0;
      r_strobe <= 1'b0;
      r_phase  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (clear) begin
        r_phase <= 1'b0;
      end else if (byte_en) begin
        if (!r_phase) begin
          r_hi    <= byte_in;
          r_phase <= 1'b1;
        end else begin
          r_pix    <= {r_hi, byte_in};
          r_strobe <= 1'b1;
          r_phase  <= 1'b0;
        end
      end
    end
  end

  assign pix        = r_pix;
  assign pix_strobe = r_strobe;
  assign phase      = r_phase;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 video capture: frame alignment, RGB565 byte pairing, pixel coordinates
// and line/frame integrity status, all in the camera PCLK domain.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          vsync_in,
  input  logic          href_in,
  input  logic [7:0]    data_in,
  output logic [15:0]   pixel_data,
  output logic          pixel_valid,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          frame_start,
  output logic          frame_done,
  output logic          line_err,
  output logic          frame_err,
  output logic [7:0]    frame_count
);

  localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);

  state_t        r_state;
  logic          r_v_q, r_v_qq, r_h_q, r_h_qq;
  logic [7:0]    r_d_q;
  logic [XW-1:0] r_x, r_px;
  logic [YW-1:0] r_y, r_py;
  logic          r_overrun;
  logic          r_frame_start, r_frame_done, r_line_err, r_frame_err;
  logic [7:0]    r_frame_count;

  logic          w_v_rise, w_v_fall, w_h_fall;
  logic          w_active, w_byte_en, w_clear;
  logic [YW-1:0] w_y_inc, w_y_eol;
  logic [15:0]   w_pix;
  logic          w_pix_strobe, w_phase;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_v_rise  = r_v_q & ~r_v_qq;
    w_v_fall  = ~r_v_q & r_v_qq;
    w_h_fall  = ~r_h_q & r_h_qq;
    w_active  = (r_state == ST_ACTIVE) & enable;
    // Bytes past the last column or below the last row are never paired.
    w_byte_en = w_active & r_h_q & ~w_v_rise & (r_x != X_END) & (r_y != Y_END);
    w_clear   = ~w_active | w_h_fall | w_v_rise;
    w_y_inc   = (r_y == Y_END) ? r_y : r_y + 1'b1;
    w_y_eol   = w_h_fall ? w_y_inc : r_y;
  end

  ov7670_byte_pair u_byte_pair (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_clear),
    .byte_en    (w_byte_en),
    .byte_in    (r_d_q),
    .pix        (w_pix),
    .pix_strobe (w_pix_strobe),
    .phase      (w_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_v_q         <= 1'b0;
      r_v_qq        <= 1'b0;
      r_h_q         <= 1'b0;
      r_h_qq        <= 1'b0;
      r_d_q         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_overrun     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_v_q         <= vsync_in;
      r_v_qq        <= r_v_q;
      r_h_q         <= href_in;
      r_h_qq        <= r_h_q;
      r_d_q         <= data_in;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;

      // Coordinates travel with the second byte so they line up with the strobe.
      if (w_byte_en && w_phase) begin
        r_px <= r_x;
        r_py <= r_y;
      end

      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT_SYNC;

          ST_WAIT_SYNC: if (w_v_rise) r_state <= ST_SYNC;

          ST_SYNC: begin
            if (w_v_fall) begin
              r_frame_start <= 1'b1;
              r_x           <= '0;
              r_y           <= '0;
              r_overrun     <= 1'b0;
              r_state       <= ST_ACTIVE;
            end
          end

          ST_ACTIVE: begin
            if (w_byte_en && w_phase) r_x <= r_x + 1'b1;
            if (r_h_q && (r_x == X_END)) r_overrun <= 1'b1;

            if (w_h_fall) begin
              r_line_err <= w_phase | (r_x != X_END) | r_overrun;
              r_x        <= '0;
              r_overrun  <= 1'b0;
              r_y        <= w_y_inc;
            end

            // A line ending on the same edge is accounted for before the frame closes.
            if (w_v_rise) begin
              r_frame_done  <= 1'b1;
              r_frame_err   <= (w_y_eol != Y_END) | r_h_q;
              r_frame_count <= r_frame_count + 8'd1;
              r_state       <= ST_SYNC;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign pixel_data  = w_pix;
  assign pixel_valid = w_pix_strobe;
  assign pixel_x     = r_px;
  assign pixel_y     = r_py;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture with a 4x2 frame: stimulus queues the
// expected events, a negedge monitor pops and compares them as the DUT emits them.
module tb_ov7670_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 10;
  localparam int YW = 9;

  typedef struct {
    logic [15:0]   d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          vsync_in = 1'b0;
  logic          href_in = 1'b0;
  logic [7:0]    data_in = '0;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          frame_start, frame_done, line_err, frame_err;
  logic [7:0]    frame_count;

  int checks = 0;
  int errors = 0;

  pix_t       pix_q[$];
  logic [8:0] fdone_q[$];
  int         lerr_pending = 0;
  int         fstart_pending = 0;
  logic [7:0] exp_count = '0;

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .vsync_in    (vsync_in),
    .href_in     (href_in),
    .data_in     (data_in),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        if (pix_q.size() == 0) check("pixel_valid unexpected", pixel_valid, 0);
        else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pixel_data", pixel_data, e.d);
          check("pixel_xy", {pixel_x, pixel_y}, {e.x, e.y});
        end
      end
      if (line_err) begin
        if (lerr_pending == 0) check("line_err unexpected", line_err, 0);
        else lerr_pending--;
      end
      if (frame_start) begin
        if (fstart_pending == 0) check("frame_start unexpected", frame_start, 0);
        else fstart_pending--;
      end
      if (frame_done) begin
        if (fdone_q.size() == 0) check("frame_done unexpected", frame_done, 0);
        else check("frame_err/count", {frame_err, frame_count}, fdone_q.pop_front());
      end else if (frame_err) begin
        check("frame_err without frame_done", frame_err, 0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    href_in = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_raw(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      href_in = 1'b1;
      data_in = base + 8'(i);
      cycle();
    end
  endtask

  // Sends n bytes base, base+1, ...; queues the pixels a correct capture must emit.
  task automatic line(input int n, input logic [7:0] base, input int y, input bit exp_err);
    for (int i = 0; i < n; i++) begin
      if ((i % 2 == 1) && (i / 2 < H) && (y < V)) begin
        pix_t p;
        logic [7:0] hi, lo;
        hi = base + 8'(i - 1);
        lo = base + 8'(i);
        p.d = {hi, lo};
        p.x = XW'(i / 2);
        p.y = YW'(y);
        pix_q.push_back(p);
      end
      href_in = 1'b1;
      data_in = base + 8'(i);
      cycle();
    end
    if (exp_err) lerr_pending++;
  endtask

  // HREF drops on the same cycle VSYNC rises, so a line still open ends with it.
  task automatic vsync_pulse(input bit exp_done, input bit exp_err);
    if (exp_done) begin
      exp_count++;
      fdone_q.push_back({exp_err, exp_count});
    end
    href_in  = 1'b0;
    vsync_in = 1'b1;
    repeat (4) cycle();
    fstart_pending++;
    vsync_in = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pixel_data"}, pixel_data, 0);
    check({tag, " pixel_xy"}, {pixel_x, pixel_y}, 0);
    check({tag, " strobes"}, {pixel_valid, frame_start, frame_done, line_err, frame_err}, 0);
    check({tag, " frame_count"}, frame_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #12;
    check_all_zero("reset");
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Clean frame: line 0 yields 0x0001 0x0203 0x0405 0x0607.
    enable = 1'b1;
    repeat (3) cycle();
    vsync_pulse(1'b0, 1'b0);
    line(8, 8'h00, 0, 1'b0); idle(4);
    line(8, 8'h08, 1, 1'b0); idle(4);
    vsync_pulse(1'b1, 1'b0);

    // Odd-length line, then a clean line restarting at x=0.
    line(7, 8'h10, 0, 1'b1); idle(4);
    line(8, 8'h20, 1, 1'b0); idle(4);
    vsync_pulse(1'b1, 1'b0);

    // Short frame: only one line.
    line(8, 8'h30, 0, 1'b0); idle(4);
    vsync_pulse(1'b1, 1'b1);

    // Overrun line, clean line, then a surplus third line.
    line(10, 8'h40, 0, 1'b1); idle(4);
    line(8, 8'h50, 1, 1'b0); idle(4);
    line(8, 8'h60, 2, 1'b1); idle(4);
    vsync_pulse(1'b1, 1'b0);

    // Enable raised mid-line: nothing until a full VSYNC high-low.
    enable = 1'b0;
    repeat (3) cycle();
    send_raw(3, 8'h70);
    enable = 1'b1;
    send_raw(5, 8'h73); idle(4);
    send_raw(8, 8'h78); idle(4);
    vsync_pulse(1'b0, 1'b0);
    line(8, 8'h80, 0, 1'b0); idle(4);
    line(8, 8'h88, 1, 1'b0);
    vsync_pulse(1'b1, 1'b0);
    check("frame_count after 5 frames", frame_count, 5);

    // Asynchronous reset in the middle of an active line.
    send_raw(1, 8'hAA);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-frame reset");
    pix_q.delete();
    lerr_pending = 0;
    repeat (2) cycle();
    rst_n = 1'b1;
    exp_count = '0;
    repeat (2) cycle();
    send_raw(8, 8'h90); idle(4);
    send_raw(8, 8'h98); idle(4);
    vsync_pulse(1'b0, 1'b0);

    // 256 clean frames wrap frame_count back to 0.
    for (int f = 0; f < 256; f++) begin
      line(8, 8'hA0, 0, 1'b0); idle(2);
      line(8, 8'hB0, 1, 1'b0); idle(2);
      vsync_pulse(1'b1, 1'b0);
    end
    repeat (4) cycle();
    check("frame_count wrapped", frame_count, 0);

    check("pixels outstanding", pix_q.size(), 0);
    check("frame_done outstanding", fdone_q.size(), 0);
    check("line_err outstanding", lerr_pending, 0);
    check("frame_start outstanding", fstart_pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream neighbour of the camera configuration block; consumes the OV7670 parallel video bus (VSYNC, HREF, D[7:0]) once register configuration reports done.
- Aligns to frame boundaries, pairs bytes into RGB565 pixels, and tracks pixel/line coordinates.
- Emits one-cycle pixel strobes plus frame/line status for a downstream frame buffer or stream writer.

Parameters:
- H_ACTIVE, 640, pixels per line (2*H_ACTIVE bytes per HREF pulse)
- V_ACTIVE, 480, lines per frame
- XW, 10, width of pixel_x (must satisfy 2^XW > H_ACTIVE)
- YW, 9, width of pixel_y (must satisfy 2^YW > V_ACTIVE)

Ports:
- clk  in  1  camera PCLK; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  capture permitted; tied to configuration done
- vsync_in  in  1  camera VSYNC, active-high pulse at frame start
- href_in  in  1  camera HREF, high during active bytes
- data_in  in  8  camera byte bus
- pixel_data  out  16  RGB565 pixel, first byte in [15:8], second byte in [7:0]
- pixel_valid  out  1  one-cycle strobe; pixel_data/x/y valid
- pixel_x  out  XW  column of current pixel, 0..H_ACTIVE-1
- pixel_y  out  YW  row of current pixel, 0..V_ACTIVE-1
- frame_start  out  1  one-cycle pulse at VSYNC falling edge (active region begins)
- frame_done  out  1  one-cycle pulse when a captured frame closes
- line_err  out  1  one-cycle pulse on a malformed line
- frame_err  out  1  one-cycle pulse with frame_done if line count != V_ACTIVE
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, byte phase 0, input registers 0.
- Input stage: vsync_in, href_in, data_in registered once (v_q, h_q, d_q). Edge detects compare against a second delayed copy.
- States:
  - IDLE: wait for enable=1, then go to WAIT_SYNC.
  - WAIT_SYNC: discard everything until a v_q rising edge, then go to SYNC. This drops any partial frame in progress at enable.
  - SYNC: wait for the v_q falling edge, then pulse frame_start, clear x, y and byte phase, and go to ACTIVE.
  - ACTIVE: capture bytes. A v_q rising edge pulses frame_done and goes to SYNC.
- enable=0 in any state: next cycle enters IDLE; the in-flight pixel is dropped and no frame_done is issued. Strobes are 0 while in IDLE.
- Byte pairing, in ACTIVE with h_q=1:
  - Phase 0: latch d_q as the high byte.
  - Phase 1: form the pixel; pixel_valid=1 on the following edge with pixel_x=x and pixel_y=y; x increments.
  - Latency: pixel_valid rises 2 clk edges after the second byte is present on data_in.
- Overrun: a pixel with x==H_ACTIVE is not emitted. x saturates and an overrun flag is set for the line.
- Line end (h_q falling edge):
  - line_err pulses if byte phase==1 (odd byte count), x!=H_ACTIVE, or overrun.
  - Then x=0 and phase=0.
  - y increments, saturating at V_ACTIVE. Lines arriving when y==V_ACTIVE emit no pixels and pulse line_err at their end.
- Frame end (v_q rising edge in ACTIVE):
  - frame_done=1.
  - frame_err=1 in the same cycle if y!=V_ACTIVE, or if h_q=1 at that edge (truncated line).
  - frame_count increments.
- Simultaneous events:
  - h_q falling and v_q rising on the same cycle: process the line end first; frame_err uses the incremented y.
  - HREF high outside ACTIVE: ignored, no error.
- pixel_data, pixel_x and pixel_y hold their last values when pixel_valid=0.

Decomposition:
- Shared defines file ov7670_defs: state encodings (IDLE, WAIT_SYNC, SYNC, ACTIVE), default H_ACTIVE/V_ACTIVE, RGB565 field bit positions (R[15:11], G[10:5], B[4:0]).
- One sub-module, ov7670_byte_pair:
  - Owns byte phase, high-byte latch and the 16-bit assembly.
  - Inputs: clk, rst_n, clear, byte_en, byte.
  - Outputs: pix, pix_strobe, phase.
  - The top level owns the FSM, counters and error logic.

Test Plan (bench uses H_ACTIVE=4, V_ACTIVE=2):
- Reset mid-frame: assert rst_n=0 during ACTIVE -> all outputs 0 immediately; after release, no pixel_valid until a full VSYNC high-low sequence.
- Clean frame: enable=1, VSYNC pulse, 2 lines of 8 bytes 0x00..0x07 -> 8 pixel_valid strobes. Line 0 gives 0x0001, 0x0203, 0x0405, 0x0607 at x=0..3, y=0. Next VSYNC rise -> frame_done=1, frame_err=0, frame_count=1.
- Odd-length line: 7 bytes under HREF -> 3 pixels, line_err pulses once at HREF fall, next line starts at x=0 with phase 0.
- Short frame: only 1 line before VSYNC rise -> frame_done=1 with frame_err=1.
- Enable at mid-frame: assert enable while HREF active -> no pixels until the next VSYNC rise then fall; frame_start fires exactly once.
- Extra line/overrun: 10-byte line -> 4 pixels then line_err. Third line in a frame -> no pixel_valid and line_err at its end.
- Wrap: 256 clean frames -> frame_count returns to 0.
